// File: rtl/spi_cmd_parser.sv
// Purpose: decode SPI frames (opcode + payload) from spi_slave into config writes, pixel RAM writes and INFO readback.
// Latency: every output is registered and updates one clk_i cycle after the vld byte that causes it.
// Backpressure: none; every vld byte is consumed in its own cycle, so back-to-back bytes are accepted.
//
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   spi_cs_n_i              chip select (already synchronised)
//   spi_byte_vld_i/_data_i  received byte stream from spi_slave
//   spi_byte_data_o         next byte for spi_slave to shift out on MISO
//   conf_o                  4-byte config register bank (byte 0 in bits 7:0)
//   ram_wr_en_o/_addr_o/_data_o  pixel RAM write port (GRB, byte0 in bits 23:16)
//   frame_done_o            pulse when a DATA_WR frame closes after writing >=1 pixel
module spi_cmd_parser #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  CMD_CONF = 8'h2A,
    parameter logic [7:0]  CMD_DATA = 8'h2B,
    parameter logic [7:0]  CMD_INFO = 8'h2C,
    parameter logic [31:0] CONF_RST = 32'h0
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_byte_vld_i,
    input  logic [7:0]        spi_byte_data_i,
    output logic [7:0]        spi_byte_data_o,
    output logic [31:0]       conf_o,
    output logic              ram_wr_en_o,
    output logic [ADDR_W-1:0] ram_wr_addr_o,
    output logic [23:0]       ram_wr_data_o,
    output logic              frame_done_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_CONF,
        ST_DATA,
        ST_INFO,
        ST_SKIP
    } state_t;

    state_t              r_state;
    // Payload byte index for CONF writes and INFO readback; saturates at 4.
    logic [2:0]          r_byte_cnt;
    // Position of the next DATA byte within the current pixel (0..2).
    logic [1:0]          r_phase;
    // First two bytes of the pixel being assembled.
    logic [15:0]         r_pix_hold;
    logic [ADDR_W-1:0]   r_addr_cnt;
    // Set once any pixel of the current frame has been written. A flag
    // rather than a count so a frame of exactly 2**ADDR_W pixels still
    // reports completion.
    logic                r_pix_any;

    logic                w_pix_done;
    logic                w_leave;

    assign w_pix_done = (r_state == ST_DATA) && spi_byte_vld_i && (r_phase == 2'd2);
    assign w_leave    = (r_state != ST_IDLE) && spi_cs_n_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state         <= ST_IDLE;
            r_byte_cnt      <= 3'd0;
            r_phase         <= 2'd0;
            r_pix_hold      <= 16'h0;
            r_addr_cnt      <= '0;
            r_pix_any       <= 1'b0;
            spi_byte_data_o <= 8'h00;
            conf_o          <= CONF_RST;
            ram_wr_en_o     <= 1'b0;
            ram_wr_addr_o   <= '0;
            ram_wr_data_o   <= 24'h0;
            frame_done_o    <= 1'b0;
        end else begin
            ram_wr_en_o  <= 1'b0;
            frame_done_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    // Per-frame counters are cleared here so every frame starts fresh.
                    spi_byte_data_o <= 8'h00;
                    r_byte_cnt      <= 3'd0;
                    r_phase         <= 2'd0;
                    r_addr_cnt      <= '0;
                    r_pix_any       <= 1'b0;
                    if (!spi_cs_n_i) begin
                        r_state <= ST_CMD;
                    end
                end

                ST_CMD: begin
                    if (spi_byte_vld_i) begin
                        if (spi_byte_data_i == CMD_CONF) begin
                            r_state <= ST_CONF;
                        end else if (spi_byte_data_i == CMD_DATA) begin
                            r_state <= ST_DATA;
                        end else if (spi_byte_data_i == CMD_INFO) begin
                            r_state         <= ST_INFO;
                            spi_byte_data_o <= conf_o[7:0];
                            r_byte_cnt      <= 3'd1;
                        end else begin
                            r_state <= ST_SKIP;
                        end
                    end
                end

                ST_CONF: begin
                    if (spi_byte_vld_i && (r_byte_cnt < 3'd4)) begin
                        conf_o[{r_byte_cnt[1:0], 3'b000} +: 8] <= spi_byte_data_i;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end

                ST_DATA: begin
                    if (spi_byte_vld_i) begin
                        case (r_phase)
                            2'd0: begin
                                r_pix_hold[15:8] <= spi_byte_data_i;
                                r_phase          <= 2'd1;
                            end
                            2'd1: begin
                                r_pix_hold[7:0] <= spi_byte_data_i;
                                r_phase         <= 2'd2;
                            end
                            default: begin
                                ram_wr_en_o   <= 1'b1;
                                ram_wr_data_o <= {r_pix_hold, spi_byte_data_i};
                                ram_wr_addr_o <= r_addr_cnt;
                                r_addr_cnt    <= r_addr_cnt + ADDR_W'(1);
                                r_pix_any     <= 1'b1;
                                r_phase       <= 2'd0;
                            end
                        endcase
                    end
                end

                ST_INFO: begin
                    // Each clocked-out byte advances readback; past byte 3 send zeros.
                    if (spi_byte_vld_i) begin
                        if (r_byte_cnt < 3'd4) begin
                            spi_byte_data_o <= conf_o[{r_byte_cnt[1:0], 3'b000} +: 8];
                            r_byte_cnt      <= r_byte_cnt + 3'd1;
                        end else begin
                            spi_byte_data_o <= 8'h00;
                        end
                    end
                end

                default: begin
                    // ST_SKIP: unknown opcode, payload is dropped.
                end
            endcase

            // Chip-select release overrides the state transition above, but any
            // byte arriving in the same cycle has already been acted on.
            if (w_leave) begin
                r_state         <= ST_IDLE;
                spi_byte_data_o <= 8'h00;
                if ((r_state == ST_DATA) && (r_pix_any || w_pix_done)) begin
                    frame_done_o <= 1'b1;
                end
            end
        end
    end

endmodule
